// File: rtl/fc_obuf.sv
// fc_obuf: FC-layer output buffer; bit-serial accumulate, requantize, drain.
// Define FC_OBUF_RELU_EN for ReLU requantization (default: signed saturation).
module fc_obuf #(
   parameter int DATA_SIZE      = 8,
   parameter int XBAR_SIZE      = 128,
   parameter int OBUF_BUS_WIDTH = 46,
   parameter int OUT_SHIFT      = 4,
   localparam int OBUF_DATA_SIZE = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                 : 2 * DATA_SIZE + $clog2(XBAR_SIZE),
   localparam int NUM_CHANNELS  = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
   localparam int FIFO_LENGTH   = ((XBAR_SIZE / DATA_SIZE) + NUM_CHANNELS - 1)
                                 / NUM_CHANNELS,
   localparam int AW = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1,
   localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   i_clear,
   input  logic                                   i_we,
   input  logic [AW-1:0]                          i_obuf_addr,
   input  logic [BW-1:0]                          i_bit,
   input  logic [NUM_CHANNELS*OBUF_DATA_SIZE-1:0] i_data,
   input  logic                                   i_start_tx,
   output logic                                   o_we,
   output logic [DATA_SIZE-1:0]                   o_data [NUM_CHANNELS-1:0],
   output logic                                   o_busy,
   output logic                                   o_done
);

   localparam int W = OBUF_DATA_SIZE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         rd_idx;
   logic signed [W-1:0]   acc_q [FIFO_LENGTH][NUM_CHANNELS];
   logic signed [W-1:0]   acc_d [FIFO_LENGTH][NUM_CHANNELS];
   logic [DATA_SIZE-1:0]  data_q [NUM_CHANNELS-1:0];
   logic [DATA_SIZE-1:0]  data_d [NUM_CHANNELS-1:0];
   logic                  we_q, we_d;
   logic                  done_q, done_d;

   function automatic logic [DATA_SIZE-1:0] requant(
      input logic signed [W-1:0] a
   );
      logic signed [W-1:0] s;
`ifdef FC_OBUF_RELU_EN
      localparam logic signed [W-1:0] UMAX = W'((2 ** DATA_SIZE) - 1);
      s = a >>> OUT_SHIFT;
      if (s[W-1])
         requant = '0;
      else if (s > UMAX)
         requant = '1;
      else
         requant = s[DATA_SIZE-1:0];
`else
      localparam logic signed [W-1:0] SMAX = W'((2 ** (DATA_SIZE - 1)) - 1);
      localparam logic signed [W-1:0] SMIN = W'(-(2 ** (DATA_SIZE - 1)));
      s = a >>> OUT_SHIFT;
      if (s > SMAX)
         requant = {1'b0, {(DATA_SIZE - 1){1'b1}}};
      else if (s < SMIN)
         requant = {1'b1, {(DATA_SIZE - 1){1'b0}}};
      else
         requant = s[DATA_SIZE-1:0];
`endif
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      data_d  = data_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      rd_idx  = cnt_q - AW'(1);
      unique case (state_q)
         S_IDLE: begin
            rd_idx = AW'(FIFO_LENGTH - 1);
            for (int a = 0; a < FIFO_LENGTH; a++) begin
               for (int c = 0; c < NUM_CHANNELS; c++) begin
                  if (i_clear)
                     acc_d[a][c] = '0;
                  else if (i_we && i_obuf_addr == AW'(a))
                     acc_d[a][c] = acc_q[a][c]
                                 + ($signed(i_data[c*W +: W]) <<< i_bit);
               end
            end
            // First element is loaded here so o_we lines up with o_busy
            if (i_start_tx) begin
               state_d = S_DRAIN;
               cnt_d   = AW'(FIFO_LENGTH - 1);
               we_d    = 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = rd_idx;
               we_d  = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (we_d) begin
         for (int c = 0; c < NUM_CHANNELS; c++)
            data_d[c] = requant(acc_d[rd_idx][c]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '{default: '0};
         data_q  <= '{default: '0};
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

   assign o_we   = we_q;
   assign o_data = data_q;
   assign o_busy = (state_q == S_DRAIN);
   assign o_done = done_q;

endmodule

// File: tb/tb_fc_obuf.sv
// tb_fc_obuf: directed vector bench for fc_obuf at default parameters.
// Expected values follow FC_OBUF_RELU_EN when it is defined.
module tb_fc_obuf;

   localparam int W = 23;
`ifdef FC_OBUF_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear, we, start;
   logic [2:0]    addr, bp;
   logic [2*W-1:0] data;
   logic          o_we, o_busy, o_done;
   logic [7:0]    od [1:0];

   logic [7:0]    cap [8][2];
   int            nchk = 0;
   int            nerr = 0;

   typedef struct {
      logic       clr;
      logic [2:0] addr;
      logic [2:0] bp;
      int         d0;
      int         d1;
      int         el;
      logic [7:0] s0, s1, r0, r1;
   } vec_t;

   vec_t v [9];

   fc_obuf dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (clear),
      .i_we        (we),
      .i_obuf_addr (addr),
      .i_bit       (bp),
      .i_data      (data),
      .i_start_tx  (start),
      .o_we        (o_we),
      .o_data      (od),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic w, input logic [2:0] a,
                      input logic [2:0] b, input int d0, input int d1);
      clear = c;
      we    = w;
      addr  = a;
      bp    = b;
      data  = {d1[W-1:0], d0[W-1:0]};
      @(posedge clk);
      #1;
      clear = 1'b0;
      we    = 1'b0;
      data  = '0;
   endtask

   // mode 0: plain, 1: inject inputs mid-burst, 2: reset after 3rd write
   task automatic drain(input int mode, input logic ww, input int wd0);
      int np, nd, dpos, bbad;
      np = 0; nd = 0; dpos = -1; bbad = 0;
      for (int k = 0; k < 8; k++) begin
         cap[k][0] = 8'hEE;
         cap[k][1] = 8'hEE;
      end
      we    = ww;
      addr  = 3'd0;
      bp    = 3'd0;
      data  = {{W{1'b0}}, wd0[W-1:0]};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      we    = 1'b0;
      data  = '0;
      for (int cy = 0; cy < 14; cy++) begin
         if (o_busy !== o_we) bbad++;
         if (o_we === 1'b1) begin
            if (np < 8) begin
               cap[7-np][0] = od[0];
               cap[7-np][1] = od[1];
            end
            np++;
         end
         if (o_done === 1'b1) begin
            nd++;
            dpos = cy;
         end
         if (mode == 1 && cy == 2) begin
            we = 1'b1; addr = 3'd0; bp = 3'd0;
            data = {{W{1'b0}}, 23'd50};
            start = 1'b1; clear = 1'b1;
         end
         if (mode == 1 && cy == 3) begin
            we = 1'b0; start = 1'b0; clear = 1'b0; data = '0;
         end
         if (mode == 2 && cy == 3) begin
            chk("rst o_we", {31'd0, o_we}, 32'd0);
            chk("rst o_busy", {31'd0, o_busy}, 32'd0);
            rst_n = 1'b1;
         end
         if (mode == 2 && cy == 2) rst_n = 1'b0;
         @(posedge clk);
         #1;
      end
      if (mode == 2) begin
         chk("rst pulses", np, 3);
         chk("rst done", nd, 0);
      end else begin
         chk("pulses", np, 8);
         chk("done count", nd, 1);
         chk("done pos", dpos, 8);
         chk("busy vs we", bbad, 0);
      end
   endtask

   task automatic chk_el(input string tag, input int el,
                         input logic [7:0] e0, input logic [7:0] e1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s el%0d c0", tag, k), cap[k][0],
             (k == el) ? e0 : 8'h00);
         chk($sformatf("%s el%0d c1", tag, k), cap[k][1],
             (k == el) ? e1 : 8'h00);
      end
   endtask

   initial begin
      v[0] = '{1'b0, 3'd3, 3'd7, 0, 32767, 3,
               8'h00, 8'h7F, 8'h00, 8'hFF};
      v[1] = '{1'b0, 3'd5, 3'd0, -64, 0, 5,
               8'hFC, 8'h00, 8'h00, 8'h00};
      v[2] = '{1'b1, 3'd2, 3'd0, 100, 0, 2,
               8'h00, 8'h00, 8'h00, 8'h00};
      v[3] = '{1'b0, 3'd6, 3'd2, 40, -40, 6,
               8'h0A, 8'hF6, 8'h0A, 8'h00};
      v[4] = '{1'b0, 3'd1, 3'd0, -10000, 5000, 1,
               8'h80, 8'h7F, 8'h00, 8'hFF};
      v[5] = '{1'b0, 3'd4, 3'd3, -1, 15, 4,
               8'hFF, 8'h07, 8'h00, 8'h07};
      v[6] = '{1'b0, 3'd7, 3'd0, -4194304, 4194303, 7,
               8'h80, 8'h7F, 8'h00, 8'hFF};
      v[7] = '{1'b0, 3'd0, 3'd0, 2047, 2048, 0,
               8'h7F, 8'h7F, 8'h7F, 8'h80};
      v[8] = '{1'b0, 3'd2, 3'd7, 65536, 32768, 2,
               8'h00, 8'h80, 8'h00, 8'h00};

      rst_n = 1'b0;
      clear = 1'b0; we = 1'b0; start = 1'b0;
      addr = '0; bp = '0; data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset o_we", {31'd0, o_we}, 32'd0);
      chk("reset o_busy", {31'd0, o_busy}, 32'd0);
      chk("reset o_done", {31'd0, o_done}, 32'd0);
      chk("reset od0", od[0], 8'h00);
      chk("reset od1", od[1], 8'h00);
      rst_n = 1'b1;

      cyc(1'b0, 1'b1, 3'd0, 3'd0, 16, 0);
      cyc(1'b0, 1'b1, 3'd0, 3'd1, 16, 0);
      drain(0, 1'b0, 0);
      chk_el("t1", 0, 8'h03, 8'h00);

      drain(0, 1'b1, 32);
      chk_el("wr+start", 0, 8'h05, 8'h00);

      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 1'b0, 3'd0, 3'd0, 0, 0);
         cyc(v[i].clr, 1'b1, v[i].addr, v[i].bp, v[i].d0, v[i].d1);
         drain(0, 1'b0, 0);
         chk_el($sformatf("vec%0d", i), v[i].el,
                RELU ? v[i].r0 : v[i].s0,
                RELU ? v[i].r1 : v[i].s1);
      end

      cyc(1'b1, 1'b0, 3'd0, 3'd0, 0, 0);
      cyc(1'b0, 1'b1, 3'd7, 3'd0, 160, 0);
      drain(2, 1'b0, 0);
      drain(0, 1'b0, 0);
      chk_el("post rst", -1, 8'h00, 8'h00);

      cyc(1'b1, 1'b0, 3'd0, 3'd0, 0, 0);
      cyc(1'b0, 1'b1, 3'd0, 3'd0, 160, 0);
      drain(1, 1'b0, 0);
      chk_el("inject", 0, 8'h0A, 8'h00);
      drain(0, 1'b0, 0);
      chk_el("inject 2nd", 0, 8'h0A, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
